// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter: grants up to two non-conflicting writes per cycle onto register-file ports 3/4.
// Latency: grant (req_ready) is combinational; we/wa/wd appear one cycle later.
// Backpressure: a valid requester that is not granted holds until its req_ready; r15 writes are acked and dropped.
module regfile_wb_arbiter #(
    parameter int NREQ = 4,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [4*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 we3,
    output logic [3:0]           wa3,
    output logic [31:0]          wd3,
    output logic                 we4,
    output logic [3:0]           wa4,
    output logic [31:0]          wd4,
    output logic                 err_r15,
    input  logic                 clr_err,
    output logic [CNTW-1:0]      wr_count
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDXW:0] NREQ_L = NREQ[IDXW:0];

    logic [3:0]      addr_a [NREQ];
    logic [31:0]     data_a [NREQ];

    logic [IDXW-1:0] ptr_q, ptr_d;
    logic            we3_q, we3_d, we4_q, we4_d;
    logic [3:0]      wa3_q, wa3_d, wa4_q, wa4_d;
    logic [31:0]     wd3_q, wd3_d, wd4_q, wd4_d;
    logic            err_q, err_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            g1_vld, g2_vld;
    logic [IDXW-1:0] g1_idx, g2_idx;
    logic [3:0]      g1_addr, g2_addr;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i] = req_addr[4*i +: 4];
            data_a[i] = req_data[32*i +: 32];
        end
    end

    // Scan from ptr; the second grant must target a different register than the first.
    always_comb begin
        logic [IDXW:0]   idx_sum;
        logic [IDXW-1:0] idx;
        g1_vld  = 1'b0;
        g2_vld  = 1'b0;
        g1_idx  = '0;
        g2_idx  = '0;
        g1_addr = '0;
        g2_addr = '0;
        idx_sum = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_sum = {1'b0, ptr_q} + k[IDXW:0];
            if (idx_sum >= NREQ_L) begin
                idx_sum = idx_sum - NREQ_L;
            end
            idx = idx_sum[IDXW-1:0];
            if (req_valid[idx]) begin
                if (!g1_vld) begin
                    g1_vld  = 1'b1;
                    g1_idx  = idx;
                    g1_addr = addr_a[idx];
                end else if (!g2_vld && (addr_a[idx] != g1_addr)) begin
                    g2_vld  = 1'b1;
                    g2_idx  = idx;
                    g2_addr = addr_a[idx];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (g1_vld) req_ready[g1_idx] = 1'b1;
        if (g2_vld) req_ready[g2_idx] = 1'b1;
    end

    always_comb begin
        logic [IDXW-1:0] last;
        logic [IDXW:0]   nxt;
        logic            wr3, wr4, drop;
        last = g2_vld ? g2_idx : g1_idx;
        nxt  = {1'b0, last} + {{IDXW{1'b0}}, 1'b1};
        if (nxt >= NREQ_L) begin
            nxt = '0;
        end
        ptr_d = g1_vld ? nxt[IDXW-1:0] : ptr_q;

        wr3  = g1_vld && (g1_addr != 4'hF);
        wr4  = g2_vld && (g2_addr != 4'hF);
        drop = (g1_vld && (g1_addr == 4'hF)) || (g2_vld && (g2_addr == 4'hF));

        we3_d = wr3;
        we4_d = wr4;
        // Address/data hold their last written value on idle or dropped slots.
        wa3_d = wr3 ? g1_addr : wa3_q;
        wd3_d = wr3 ? data_a[g1_idx] : wd3_q;
        wa4_d = wr4 ? g2_addr : wa4_q;
        wd4_d = wr4 ? data_a[g2_idx] : wd4_q;

        if (drop)         err_d = 1'b1;
        else if (clr_err) err_d = 1'b0;
        else              err_d = err_q;

        cnt_d = cnt_q + {{(CNTW-1){1'b0}}, wr3} + {{(CNTW-1){1'b0}}, wr4};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            we3_q <= 1'b0;
            we4_q <= 1'b0;
            wa3_q <= '0;
            wa4_q <= '0;
            wd3_q <= '0;
            wd4_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            we3_q <= we3_d;
            we4_q <= we4_d;
            wa3_q <= wa3_d;
            wa4_q <= wa4_d;
            wd3_q <= wd3_d;
            wd4_q <= wd4_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign we3      = we3_q;
    assign wa3      = wa3_q;
    assign wd3      = wd3_q;
    assign we4      = we4_q;
    assign wa4      = wa4_q;
    assign wd4      = wd4_q;
    assign err_r15  = err_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=4): grant patterns, port mapping, r15 drop, reset.
module tb_regfile_wb_arbiter;

    logic         clk;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [15:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         we3, we4;
    logic [3:0]   wa3, wa4;
    logic [31:0]  wd3, wd4;
    logic         err_r15;
    logic         clr_err;
    logic [15:0]  wr_count;

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;

    regfile_wb_arbiter #(.NREQ(4), .CNTW(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4),
        .err_r15(err_r15), .clr_err(clr_err), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && we3 && we4 && (wa3 == wa4)) overlap_cnt++;
    end

    task automatic set_req(input int i, input logic [3:0] a, input logic [31:0] d);
        req_valid[i]       = 1'b1;
        req_addr[4*i +: 4]   = a;
        req_data[32*i +: 32] = d;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clr_err = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
        #3;
        checks++; if (we3 !== 1'b0 || we4 !== 1'b0) begin errors++; $display("FAIL reset_we: we3=%b we4=%b, required 0 0", we3, we4); end
        checks++; if (wa3 !== 4'd0 || wd3 !== 32'd0 || wa4 !== 4'd0 || wd4 !== 32'd0) begin errors++; $display("FAIL reset_wa_wd: wa3=%h wd3=%h wa4=%h wd4=%h, required zeros", wa3, wd3, wa4, wd4); end
        checks++; if (err_r15 !== 1'b0 || wr_count !== 16'd0) begin errors++; $display("FAIL reset_err_cnt: err=%b cnt=%0d, required 0 0", err_r15, wr_count); end
        edge1(); edge1();
        @(negedge clk); reset_n = 1'b1;
        edge1();
    endtask

    task automatic test_single();
        set_req(0, 4'd3, 32'hDEADBEEF);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b, required 0001", req_ready); end
        edge1();
        req_valid = '0;
        checks++; if (we3 !== 1'b1 || wa3 !== 4'd3 || wd3 !== 32'hDEADBEEF || we4 !== 1'b0) begin errors++; $display("FAIL single_port: we3=%b wa3=%0d wd3=%h we4=%b, required 1 3 deadbeef 0", we3, wa3, wd3, we4); end
        checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d, required 1", wr_count); end
    endtask

    task automatic test_dual();
        set_req(1, 4'd2, 32'h11111111);
        set_req(2, 4'd5, 32'h22222222);
        #1;
        checks++; if (req_ready !== 4'b0110) begin errors++; $display("FAIL dual_ready: got %b, required 0110", req_ready); end
        edge1();
        req_valid = '0;
        checks++; if (we3 !== 1'b1 || wa3 !== 4'd2 || wd3 !== 32'h11111111) begin errors++; $display("FAIL dual_port3: we3=%b wa3=%0d wd3=%h, required 1 2 11111111", we3, wa3, wd3); end
        checks++; if (we4 !== 1'b1 || wa4 !== 4'd5 || wd4 !== 32'h22222222) begin errors++; $display("FAIL dual_port4: we4=%b wa4=%0d wd4=%h, required 1 5 22222222", we4, wa4, wd4); end
        checks++; if (wr_count !== 16'd3) begin errors++; $display("FAIL dual_cnt: got %0d, required 3", wr_count); end
    endtask

    task automatic test_idle_hold();
        set_req(3, 4'd1, 32'h33333333);
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL ptr_after_dual: ready=%b, required 1000", req_ready); end
        edge1();
        req_valid = '0;
        edge1();
        checks++; if (we3 !== 1'b0 || we4 !== 1'b0 || wa3 !== 4'd1 || wd3 !== 32'h33333333) begin errors++; $display("FAIL idle_hold: we3=%b we4=%b wa3=%0d wd3=%h, required 0 0 1 33333333", we3, we4, wa3, wd3); end
        checks++; if (wr_count !== 16'd4) begin errors++; $display("FAIL idle_cnt: got %0d, required 4", wr_count); end
    endtask

    task automatic test_conflict();
        set_req(0, 4'd7, 32'hA0A0A0A0);
        set_req(1, 4'd7, 32'hA1A1A1A1);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL conflict_ready_a: got %b, required 0001", req_ready); end
        edge1();
        req_valid[0] = 1'b0;
        checks++; if (we3 !== 1'b1 || wa3 !== 4'd7 || wd3 !== 32'hA0A0A0A0 || we4 !== 1'b0) begin errors++; $display("FAIL conflict_port_a: we3=%b wa3=%0d wd3=%h we4=%b, required 1 7 a0a0a0a0 0", we3, wa3, wd3, we4); end
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL conflict_ready_b: got %b, required 0010", req_ready); end
        edge1();
        req_valid = '0;
        checks++; if (we3 !== 1'b1 || wd3 !== 32'hA1A1A1A1 || we4 !== 1'b0) begin errors++; $display("FAIL conflict_port_b: we3=%b wd3=%h we4=%b, required 1 a1a1a1a1 0", we3, wd3, we4); end
        checks++; if (wr_count !== 16'd6) begin errors++; $display("FAIL conflict_cnt: got %0d, required 6", wr_count); end
    endtask

    task automatic test_fairness();
        int gcount [4];
        logic [3:0] exp_rdy;
        set_req(3, 4'd8, 32'h00000030);
        edge1();
        req_valid = '0;
        for (int i = 0; i < 4; i++) gcount[i] = 0;
        set_req(0, 4'd1, 32'h00000100);
        set_req(1, 4'd2, 32'h00000101);
        set_req(2, 4'd3, 32'h00000102);
        set_req(3, 4'd4, 32'h00000103);
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_rdy = (k % 2 == 0) ? 4'b0011 : 4'b1100;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL fair_ready_c%0d: got %b, required %b", k, req_ready, exp_rdy); end
            for (int i = 0; i < 4; i++) if (req_ready[i] === 1'b1) gcount[i]++;
            @(posedge clk);
        end
        #1;
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (gcount[i] != 4) begin errors++; $display("FAIL fair_count_r%0d: got %0d grants, required 4", i, gcount[i]); end
        end
        checks++; if (wr_count !== 16'd23) begin errors++; $display("FAIL fair_cnt: got %0d, required 23", wr_count); end
        checks++; if (we3 !== 1'b1 || wa3 !== 4'd3 || we4 !== 1'b1 || wa4 !== 4'd4) begin errors++; $display("FAIL fair_last: we3=%b wa3=%0d we4=%b wa4=%0d, required 1 3 1 4", we3, wa3, we4, wa4); end
    endtask

    task automatic test_r15();
        set_req(2, 4'hF, 32'hBAD0BAD0);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL r15_ready: got %b, required 0100", req_ready); end
        edge1();
        req_valid = '0;
        checks++; if (we3 !== 1'b0 || we4 !== 1'b0 || err_r15 !== 1'b1) begin errors++; $display("FAIL r15_drop: we3=%b we4=%b err=%b, required 0 0 1", we3, we4, err_r15); end
        checks++; if (wr_count !== 16'd23) begin errors++; $display("FAIL r15_cnt: got %0d, required 23", wr_count); end
        clr_err = 1'b1;
        edge1();
        clr_err = 1'b0;
        checks++; if (err_r15 !== 1'b0) begin errors++; $display("FAIL r15_clear: err=%b, required 0", err_r15); end
        set_req(0, 4'hF, 32'h0);
        clr_err = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL r15_wrap_ready: got %b, required 0001", req_ready); end
        edge1();
        req_valid = '0; clr_err = 1'b0;
        checks++; if (err_r15 !== 1'b1) begin errors++; $display("FAIL r15_set_wins: err=%b, required 1", err_r15); end
        set_req(1, 4'd4, 32'h44444444);
        set_req(2, 4'hF, 32'h55555555);
        #1;
        checks++; if (req_ready !== 4'b0110) begin errors++; $display("FAIL r15_g2_ready: got %b, required 0110", req_ready); end
        edge1();
        req_valid = '0;
        checks++; if (we3 !== 1'b1 || wa3 !== 4'd4 || wd3 !== 32'h44444444 || we4 !== 1'b0) begin errors++; $display("FAIL r15_g2_port: we3=%b wa3=%0d wd3=%h we4=%b, required 1 4 44444444 0", we3, wa3, wd3, we4); end
        checks++; if (wr_count !== 16'd24) begin errors++; $display("FAIL r15_g2_cnt: got %0d, required 24", wr_count); end
    endtask

    task automatic test_async_reset();
        set_req(2, 4'd9, 32'h99999999);
        edge1();
        req_valid = '0;
        checks++; if (we3 !== 1'b1 || wa3 !== 4'd9) begin errors++; $display("FAIL areset_pre: we3=%b wa3=%0d, required 1 9", we3, wa3); end
        #3;
        reset_n = 1'b0;
        #2;
        checks++; if (we3 !== 1'b0 || we4 !== 1'b0 || wr_count !== 16'd0 || err_r15 !== 1'b0) begin errors++; $display("FAIL areset_now: we3=%b we4=%b cnt=%0d err=%b, required 0 0 0 0", we3, we4, wr_count, err_r15); end
        @(negedge clk);
        reset_n = 1'b1;
        edge1();
        set_req(0, 4'd1, 32'hC0C0C0C0);
        set_req(1, 4'd2, 32'hC1C1C1C1);
        set_req(2, 4'd3, 32'hC2C2C2C2);
        set_req(3, 4'd4, 32'hC3C3C3C3);
        #1;
        checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL areset_ptr: ready=%b, required 0011", req_ready); end
        edge1();
        req_valid = '0;
        checks++; if (we3 !== 1'b1 || wd3 !== 32'hC0C0C0C0 || we4 !== 1'b1 || wd4 !== 32'hC1C1C1C1 || wr_count !== 16'd2) begin errors++; $display("FAIL areset_first: we3=%b wd3=%h we4=%b wd4=%h cnt=%0d, required 1 c0c0c0c0 1 c1c1c1c1 2", we3, wd3, we4, wd4, wr_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_idle_hold();
        test_conflict();
        test_fairness();
        test_r15();
        test_async_reset();
        edge1();
        checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL same_addr_overlap: %0d cycles, required 0", overlap_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
